// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and default sizes for the debouncer.
// Holds the per-channel state type and default W, N, S values.
package debounce_pkg;

   typedef enum logic [1:0] {
      zero,
      wait1,
      one,
      wait0
   } db_state_t;

   localparam int DB_W = 4;
   localparam int DB_N = 22;
   localparam int DB_S = 2;

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one channel = S-flop synchroniser + FSMD + down-counter.
// Ports: i_clk, i_rst_n, i_sw (raw), o_level, o_rise, o_fall (registered),
//        o_tick_nxt (comb. value the rise|fall registers load next edge).
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int N = DB_N,
   parameter int S = DB_S
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall,
   output logic o_tick_nxt
);

   logic [S-1:0] r_sync;
   db_state_t    r_state;
   db_state_t    w_state_nxt;
   logic [N-1:0] r_q;
   logic [N-1:0] w_q_nxt;
   logic         w_s;
   logic         w_rise_nxt;
   logic         w_fall_nxt;
   logic         r_level;
   logic         r_rise;
   logic         r_fall;

   assign w_s = r_sync[S-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= '0;
         r_state <= zero;
         r_q     <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[S-2:0], i_sw};
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_level <= (w_state_nxt == one) || (w_state_nxt == wait0);
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      case (r_state)
         zero: begin
            if (w_s) begin
               w_state_nxt = wait1;
               w_q_nxt     = '1;
            end
         end
         wait1: begin
            if (!w_s)
               w_state_nxt = zero;
            else if (r_q == '0)
               w_state_nxt = one;
            else
               w_q_nxt = r_q - N'(1);
         end
         one: begin
            if (!w_s) begin
               w_state_nxt = wait0;
               w_q_nxt     = '1;
            end
         end
         wait0: begin
            if (w_s)
               w_state_nxt = one;
            else if (r_q == '0)
               w_state_nxt = zero;
            else
               w_q_nxt = r_q - N'(1);
         end
         default: w_state_nxt = zero;
      endcase
   end

   // A tick only on a completed qualification, never on a glitch return.
   assign w_rise_nxt = (r_state == wait1) && (w_state_nxt == one);
   assign w_fall_nxt = (r_state == wait0) && (w_state_nxt == zero);

   assign o_level    = r_level;
   assign o_rise     = r_rise;
   assign o_fall     = r_fall;
   assign o_tick_nxt = w_rise_nxt | w_fall_nxt;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: W independent debounce channels plus a registered any_tick.
// Ports: clk, reset_n (async, active-low), sw[W], db_level[W], rise_tick[W],
//        fall_tick[W], any_tick (aligned with the tick bits).
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int W = DB_W,
   parameter int N = DB_N,
   parameter int S = DB_S
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] sw,
   output logic [W-1:0] db_level,
   output logic [W-1:0] rise_tick,
   output logic [W-1:0] fall_tick,
   output logic         any_tick
);

   logic [W-1:0] w_tick_nxt;
   logic         r_any;

   for (genvar g = 0; g < W; g++) begin : g_chan
      debounce_chan #(
         .N (N),
         .S (S)
      ) u_chan (
         .i_clk      (clk),
         .i_rst_n    (reset_n),
         .i_sw       (sw[g]),
         .o_level    (db_level[g]),
         .o_rise     (rise_tick[g]),
         .o_fall     (fall_tick[g]),
         .o_tick_nxt (w_tick_nxt[g])
      );
   end

   // OR the next-cycle tick values so any_tick lands with the ticks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_any <= 1'b0;
      else
         r_any <= |w_tick_nxt;
   end

   assign any_tick = r_any;

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed + random stimulus against a run-length model.
// Model: level flips after 2^N+1 consecutive synchronised opposite samples.
module tb_debounce_multi;

   localparam int W   = 4;
   localparam int N   = 3;
   localparam int S   = 2;
   localparam int WIN = 1 << N;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [W-1:0] sw;
   logic [W-1:0] db_level;
   logic [W-1:0] rise_tick;
   logic [W-1:0] fall_tick;
   logic         any_tick;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] m_lvl;
   logic [W-1:0] m_rise;
   logic [W-1:0] m_fall;
   logic         m_any;
   int           m_run [W];
   logic [W-1:0] m_pipe [S];

   debounce_multi #(
      .W (W),
      .N (N),
      .S (S)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw        (sw),
      .db_level  (db_level),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick),
      .any_tick  (any_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void m_clear();
      m_lvl  = '0;
      m_rise = '0;
      m_fall = '0;
      m_any  = 1'b0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      for (int k = 0; k < S; k++) m_pipe[k] = '0;
   endfunction

   function automatic void m_edge(input logic [W-1:0] v);
      logic [W-1:0] s;
      s      = m_pipe[S-1];
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
         if (s[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == WIN + 1) begin
               m_lvl[i] = s[i];
               if (s[i]) m_rise[i] = 1'b1;
               else      m_fall[i] = 1'b1;
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_any = |(m_rise | m_fall);
      for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = v;
   endfunction

   task automatic cmp_all();
      chk("level", 32'(db_level), 32'(m_lvl));
      chk("rise", 32'(rise_tick), 32'(m_rise));
      chk("fall", 32'(fall_tick), 32'(m_fall));
      chk("any", 32'(any_tick), 32'(m_any));
   endtask

   // Entered and left at a negedge.
   task automatic step(input logic [W-1:0] v);
      sw = v;
      @(posedge clk);
      m_edge(v);
      #1;
      cmp_all();
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [W-1:0] v);
      sw      = v;
      reset_n = 1'b0;
      #1;
      m_clear();
      cmp_all();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int lat;
      int cnt_a;
      int cnt_b;
      logic [W-1:0] cur;
      logic [W-1:0] mode;

      reset_n = 1'b1;
      sw      = '0;
      m_clear();
      @(negedge clk);
      do_reset('0);

      // clean press on channel 0
      repeat (3) step(4'b0000);
      lat   = 0;
      cnt_a = 0;
      cnt_b = 0;
      for (int k = 1; k <= 20; k++) begin
         step(4'b0001);
         if (db_level[0] && lat == 0) lat = k;
         if (rise_tick[0]) cnt_a++;
         if (any_tick) cnt_b++;
      end
      chk("press_lat", lat, 11);
      chk("press_rise_cnt", cnt_a, 1);
      chk("press_any_cnt", cnt_b, 1);

      // bounce on channel 1
      cnt_a = 0;
      for (int b = 0; b < 4; b++)
         repeat (3) begin
            step((b % 2 == 0) ? 4'b0011 : 4'b0001);
            if (rise_tick[1]) cnt_a++;
         end
      chk("bounce_ticks", cnt_a, 0);
      lat = 0;
      for (int k = 1; k <= 15; k++) begin
         step(4'b0011);
         if (rise_tick[1]) begin
            cnt_a++;
            if (lat == 0) lat = k;
         end
      end
      chk("bounce_lat", lat, 11);
      chk("bounce_rise_cnt", cnt_a, 1);

      // release glitch on channel 2
      repeat (14) step(4'b0111);
      chk("glitch_pre_lvl", 32'(db_level[2]), 1);
      cnt_a = 0;
      cnt_b = 0;
      for (int k = 0; k < 17; k++) begin
         step(k < 5 ? 4'b0011 : 4'b0111);
         if (fall_tick[2]) cnt_a++;
         if (any_tick) cnt_b++;
         if (db_level[2] !== 1'b1) cnt_b++;
      end
      chk("glitch_fall", cnt_a, 0);
      chk("glitch_any", cnt_b, 0);

      // simultaneous channels
      repeat (14) step(4'b0000);
      cnt_a = 0;
      cnt_b = 0;
      for (int k = 0; k < 14; k++) begin
         step(4'b1111);
         if (rise_tick == 4'b1111) cnt_a++;
         if (any_tick) cnt_b++;
      end
      chk("simul_rise", cnt_a, 1);
      chk("simul_any", cnt_b, 1);
      lat = 0;
      for (int k = 1; k <= 14; k++) begin
         step(4'b0000);
         if (fall_tick == 4'b1111 && lat == 0) lat = k;
      end
      chk("simul_fall_lat", lat, 11);

      // reset mid-window on channel 0
      repeat (2) step(4'b0000);
      repeat (8) step(4'b0001);
      do_reset(4'b0001);
      lat = 0;
      for (int k = 1; k <= 15; k++) begin
         step(4'b0001);
         if (rise_tick[0] && lat == 0) lat = k;
      end
      chk("rst_relat", lat, 11);

      // long hold
      repeat (14) step(4'b0000);
      cnt_a = 0;
      for (int k = 0; k < 100; k++) begin
         step(4'b0001);
         if (rise_tick[0]) cnt_a++;
      end
      chk("hold_rise_cnt", cnt_a, 1);
      chk("hold_level", 32'(db_level[0]), 1);

      // random: per-channel noisy or quiet phases
      cur  = '0;
      mode = '0;
      for (int k = 0; k < 3000; k++) begin
         if (k % 16 == 0) mode = W'($urandom);
         for (int i = 0; i < W; i++) begin
            if (mode[i]) begin
               if ($urandom_range(2, 0) == 0) cur[i] = ~cur[i];
            end else begin
               if ($urandom_range(39, 0) == 0) cur[i] = ~cur[i];
            end
         end
         if (k == 1500) do_reset(cur);
         step(cur);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
